// File: rtl/mm_pkg.sv
// Shared types and constants for the matrix memory responder.
// Index helper keeps the row-major mapping in one place.
package mm_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int SRC_W   = 20;
  localparam int RES_W   = 40;
  localparam int DIM_DEF = 4;

  // Row-major linear index; callers guarantee r,c < dim <= 8.
  function automatic logic [6:0] lin_idx(input logic [2:0] r, input logic [2:0] c,
                                         input int dim);
    return 7'(r) * 7'(dim) + 7'(c);
  endfunction

endpackage

// File: rtl/mm_bank.sv
// Simple storage bank: synchronous write, combinational read, no reset on contents.
module mm_bank #(
  parameter int W     = 20,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mm_mem_resp.sv
// Matrix memory responder: loads a DIMxDIM source matrix, then serves element
// reads and result writes until the initiator reports finish.
module mm_mem_resp import mm_pkg::*; #(
  parameter int DIM  = DIM_DEF,
  parameter int IDXW = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDXW-1:0]  i,
  input  logic [IDXW-1:0]  j,
  input  logic             read,
  input  logic             write,
  input  logic [RES_W-1:0] write_data,
  input  logic             finish,
  output logic [SRC_W-1:0] read_data,
  input  logic             load_valid,
  input  logic [SRC_W-1:0] load_data,
  output logic             load_ready,
  input  logic [5:0]       res_addr,
  output logic [RES_W-1:0] res_data,
  output logic             ready,
  output logic             done,
  output logic             err,
  output logic [6:0]       wr_count
);

  localparam int              DEPTH    = DIM * DIM;
  localparam int              AW       = $clog2(DEPTH);
  // Banks and flags are sized to a power of two so every AW-bit address is in bounds.
  localparam int              PDEPTH   = 1 << AW;
  localparam logic [6:0]      LAST_IDX = 7'(DEPTH - 1);
  localparam logic [6:0]      DEPTH7   = 7'(DEPTH);
  localparam logic [IDXW-1:0] DIM_I    = IDXW'(DIM);

  state_t state_q, state_d;

  logic [6:0]        ld_cnt_q;
  logic [SRC_W-1:0]  rd_data_q;
  logic [6:0]        wr_cnt_q;
  logic              err_q;
  logic [PDEPTH-1:0] written_q;

  logic              in_load, in_serve, in_rng;
  logic              ld_we, rd_acc, wr_ok, err_set;
  logic [AW-1:0]     rw_addr, res_idx;
  logic [SRC_W-1:0]  src_rdata;
  logic [RES_W-1:0]  res_rdata;
  logic              res_hit;

  assign in_load  = (state_q == ST_LOAD);
  assign in_serve = (state_q == ST_SERVE);
  assign in_rng   = (i < DIM_I) && (j < DIM_I);
  assign rw_addr  = AW'(lin_idx(i[2:0], j[2:0], DIM));
  assign res_idx  = res_addr[AW-1:0];

  assign ld_we   = in_load && load_valid;
  assign rd_acc  = in_serve && read;
  assign wr_ok   = in_serve && write && in_rng;
  assign err_set = (in_load && (read || write || finish)) ||
                   (in_serve && (read || write) && !in_rng);

  mm_bank #(.W(SRC_W), .DEPTH(PDEPTH), .AW(AW)) u_src (
    .clk     (clk),
    .we_i    (ld_we),
    .waddr_i (ld_cnt_q[AW-1:0]),
    .wdata_i (load_data),
    .raddr_i (rw_addr),
    .rdata_o (src_rdata)
  );

  mm_bank #(.W(RES_W), .DEPTH(PDEPTH), .AW(AW)) u_res (
    .clk     (clk),
    .we_i    (wr_ok),
    .waddr_i (rw_addr),
    .wdata_i (write_data),
    .raddr_i (res_idx),
    .rdata_o (res_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_LOAD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD:  if (ld_we && (ld_cnt_q == LAST_IDX)) state_d = ST_SERVE;
      ST_SERVE: if (finish) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    load_ready = 1'b0;
    ready      = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_LOAD:  load_ready = 1'b1;
      ST_SERVE: ready      = 1'b1;
      ST_DONE:  done       = 1'b1;
      default:  load_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_cnt_q  <= '0;
      rd_data_q <= '0;
      wr_cnt_q  <= '0;
      err_q     <= 1'b0;
      written_q <= '0;
    end else begin
      if (ld_we)  ld_cnt_q  <= ld_cnt_q + 7'd1;
      if (rd_acc) rd_data_q <= in_rng ? src_rdata : '0;
      if (wr_ok) begin
        written_q[rw_addr] <= 1'b1;
        if (wr_cnt_q != 7'h7F) wr_cnt_q <= wr_cnt_q + 7'd1;
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  // Written flags hide whatever a previous run left in the result bank.
  assign res_hit  = ({1'b0, res_addr} < DEPTH7) && written_q[res_idx];
  assign res_data = res_hit ? res_rdata : '0;

  assign read_data = rd_data_q;
  assign wr_count  = wr_cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mm_mem_resp.sv
// Directed bench for mm_mem_resp (DIM=4): load, serve, range errors, finish, reset.
module tb_mm_mem_resp;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] i = '0, j = '0;
  logic        read = 1'b0, write = 1'b0, finish = 1'b0;
  logic [39:0] write_data = '0;
  logic [19:0] read_data;
  logic        load_valid = 1'b0;
  logic [19:0] load_data = '0;
  logic        load_ready;
  logic [5:0]  res_addr = '0;
  logic [39:0] res_data;
  logic        ready, done, err;
  logic [6:0]  wr_count;

  int checks = 0;
  int failures = 0;

  mm_mem_resp #(.DIM(4), .IDXW(20)) dut (
    .clk        (clk),
    .reset      (reset),
    .i          (i),
    .j          (j),
    .read       (read),
    .write      (write),
    .write_data (write_data),
    .finish     (finish),
    .read_data  (read_data),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .res_addr   (res_addr),
    .res_data   (res_data),
    .ready      (ready),
    .done       (done),
    .err        (err),
    .wr_count   (wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state, sampled while reset is held
    #13;
    chk("rst_load_ready", 40'(load_ready), 40'd1);
    chk("rst_ready", 40'(ready), 40'd0);
    chk("rst_done", 40'(done), 40'd0);
    chk("rst_err", 40'(err), 40'd0);
    chk("rst_wr_count", 40'(wr_count), 40'd0);
    chk("rst_read_data", 40'(read_data), 40'd0);
    chk("rst_res_data", res_data, 40'd0);
    tick();
    reset = 1'b0;

    // load 1..16
    for (int k = 0; k < 16; k++) begin
      load_valid = 1'b1;
      load_data  = 20'(k + 1);
      if (k == 15) chk("load_not_ready_before_last", 40'(ready), 40'd0);
      tick();
    end
    load_valid = 1'b0;
    chk("serve_ready", 40'(ready), 40'd1);
    chk("serve_load_ready", 40'(load_ready), 40'd0);

    // read (2,3) -> 12
    i = 20'd2; j = 20'd3; read = 1'b1;
    tick();
    read = 1'b0;
    chk("read_2_3", 40'(read_data), 40'd12);
    chk("err_after_good_read", 40'(err), 40'd0);

    res_addr = 6'd5;
    #1;
    chk("res5_unwritten", res_data, 40'd0);

    // write (1,1) and read (1,1) same cycle
    i = 20'd1; j = 20'd1; read = 1'b1; write = 1'b1; write_data = 40'h12345;
    tick();
    read = 1'b0; write = 1'b0;
    chk("read_1_1", 40'(read_data), 40'd6);
    chk("wr_count_1", 40'(wr_count), 40'd1);
    chk("res5_written", res_data, 40'h12345);
    res_addr = 6'd6;
    #1;
    chk("res6_unwritten", res_data, 40'd0);

    // out-of-range read
    i = 20'd4; j = 20'd0; read = 1'b1;
    tick();
    read = 1'b0;
    chk("read_oor_data", 40'(read_data), 40'd0);
    chk("read_oor_err", 40'(err), 40'd1);

    // out-of-range write dropped
    i = 20'd0; j = 20'd7; write = 1'b1; write_data = 40'hDEAD;
    tick();
    write = 1'b0;
    chk("write_oor_count", 40'(wr_count), 40'd1);
    res_addr = 6'd7;
    #1;
    chk("res7_after_oor_write", res_data, 40'd0);

    // corner element write
    i = 20'd3; j = 20'd3; write = 1'b1; write_data = 40'hAB_CDEF_0123;
    tick();
    write = 1'b0;
    chk("wr_count_2", 40'(wr_count), 40'd2);
    res_addr = 6'd15;
    #1;
    chk("res15", res_data, 40'hAB_CDEF_0123);
    res_addr = 6'd40;
    #1;
    chk("res_addr_oor", res_data, 40'd0);

    // finish with a simultaneous write
    i = 20'd0; j = 20'd0; write = 1'b1; write_data = 40'd5; finish = 1'b1;
    tick();
    write = 1'b0; finish = 1'b0;
    chk("finish_done", 40'(done), 40'd1);
    chk("finish_ready", 40'(ready), 40'd0);
    chk("finish_wr_count", 40'(wr_count), 40'd3);
    res_addr = 6'd0;
    #1;
    chk("res0_finish_write", res_data, 40'd5);

    // writes ignored in DONE
    i = 20'd2; j = 20'd2; write = 1'b1; write_data = 40'h77;
    tick();
    write = 1'b0;
    chk("done_write_ignored", 40'(wr_count), 40'd3);
    chk("done_still", 40'(done), 40'd1);
    res_addr = 6'd10;
    #1;
    chk("res10_after_done_write", res_data, 40'd0);

    // reset out of DONE
    reset = 1'b1;
    #1;
    chk("rst2_load_ready", 40'(load_ready), 40'd1);
    chk("rst2_done", 40'(done), 40'd0);
    chk("rst2_err", 40'(err), 40'd0);
    tick();
    reset = 1'b0;

    // read during LOAD after 3 words
    for (int k = 0; k < 3; k++) begin
      load_valid = 1'b1;
      load_data  = 20'(21 + k);
      tick();
    end
    load_valid = 1'b0;
    chk("load3_err", 40'(err), 40'd0);
    i = 20'd0; j = 20'd0; read = 1'b1;
    tick();
    read = 1'b0;
    chk("load_read_err", 40'(err), 40'd1);
    chk("load_read_ignored", 40'(read_data), 40'd0);
    chk("load_read_still_loading", 40'(load_ready), 40'd1);
    for (int k = 3; k < 16; k++) begin
      load_valid = 1'b1;
      load_data  = 20'(21 + k);
      tick();
    end
    load_valid = 1'b0;
    chk("reload_ready", 40'(ready), 40'd1);

    i = 20'd0; j = 20'd3; read = 1'b1;
    tick();
    read = 1'b0;
    chk("reload_read_0_3", 40'(read_data), 40'd24);

    i = 20'd0; j = 20'd0; write = 1'b1; write_data = 40'h111;
    tick();
    i = 20'd3; j = 20'd2; write_data = 40'h222;
    tick();
    write = 1'b0;
    chk("reload_wr_count", 40'(wr_count), 40'd2);

    // asynchronous reset mid-SERVE
    #2;
    reset = 1'b1;
    #1;
    chk("rst3_load_ready", 40'(load_ready), 40'd1);
    chk("rst3_ready", 40'(ready), 40'd0);
    chk("rst3_wr_count", 40'(wr_count), 40'd0);
    for (int a = 0; a < 16; a++) begin
      res_addr = 6'(a);
      #1;
      chk($sformatf("rst3_res%0d", a), res_data, 40'd0);
    end
    tick();
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
